// File: rtl/log_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : log_result_stage
//  Purpose  : Registered output stage behind the 16-bit logic unit. Captures
//             result + select code, derives status flags at capture time,
//             tags each accepted result with a sequence number and forwards
//             it through a valid/ready handshake. A main register plus one
//             skid register keep full throughput while in_ready stays a
//             registered (out_ready-independent) signal.
//  Revision : 1.0 - initial release
// ============================================================================
module log_result_stage #(
    parameter int DW   = 16,
    parameter int TAGW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   lout,
    input  logic [3:0]      sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [3:0]      out_sel,
    output logic [TAGW-1:0] out_tag,
    output logic            out_zero,
    output logic            out_neg,
    output logic            out_par,
    output logic            out_const,
    output logic [15:0]     xfer_cnt
);

    // Select codes whose logic-unit result does not depend on the operands
    localparam logic [3:0]      c_SEL_CONST_A = 4'b0011;
    localparam logic [3:0]      c_SEL_CONST_B = 4'b1100;
    localparam logic [TAGW-1:0] c_TAG_ONE     = {{(TAGW-1){1'b0}}, 1'b1};
    localparam logic [15:0]     c_XFER_ONE    = 16'd1;

    // One buffered result with its precomputed status flags
    typedef struct packed {
        logic [TAGW-1:0] tag;
        logic [3:0]      sel;
        logic            cnst;
        logic            par;
        logic            neg;
        logic            zero;
        logic [DW-1:0]   data;
    } entry_t;

    // Occupancy: EMPTY, ONE (main only), FULL (main + skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    occ_t            r_state;
    entry_t          r_main;
    entry_t          r_skid;
    logic [TAGW-1:0] r_tag;
    logic [15:0]     r_xfer;

    entry_t          w_new;
    logic            w_accept;
    logic            w_drain;

    // Handshake decode: both terms come straight from registered state
    // (in_ready is additionally forced low while rst is asserted)
    always_comb begin
        in_ready  = (r_state != ST_FULL) & ~rst;
        out_valid = (r_state != ST_EMPTY);
        w_accept  = in_valid & in_ready;
        w_drain   = out_valid & out_ready;
    end

    // Build the entry to capture: flags come from lout, const from sel only
    always_comb begin
        w_new      = '0;
        w_new.data = lout;
        w_new.zero = (lout == '0);
        w_new.neg  = lout[DW-1];
        w_new.par  = ^lout;
        w_new.cnst = (sel == c_SEL_CONST_A) || (sel == c_SEL_CONST_B);
        w_new.sel  = sel;
        w_new.tag  = r_tag;
    end

    // Occupancy state machine, storage registers and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_tag   <= '0;
            r_xfer  <= '0;
        end else begin
            // The tag is consumed by every accept, even one dropped by flush,
            // so the consumer can detect the gap from the tag sequence.
            if (w_accept) begin
                r_tag <= r_tag + c_TAG_ONE;
            end
            if (w_drain) begin
                r_xfer <= r_xfer + c_XFER_ONE;
            end

            if (flush) begin
                r_state <= ST_EMPTY;
            end else begin
                case (r_state)
                    ST_EMPTY: begin
                        if (w_accept) begin
                            r_main  <= w_new;
                            r_state <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (w_accept && w_drain) begin
                            r_main <= w_new;
                        end else if (w_accept) begin
                            r_skid  <= w_new;
                            r_state <= ST_FULL;
                        end else if (w_drain) begin
                            r_state <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        // No accept is possible here; skid moves up in order
                        if (w_drain) begin
                            r_main  <= r_skid;
                            r_state <= ST_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_EMPTY;
                    end
                endcase
            end
        end
    end

    // Outputs come directly from the main register
    always_comb begin
        out_data  = r_main.data;
        out_sel   = r_main.sel;
        out_tag   = r_main.tag;
        out_zero  = r_main.zero;
        out_neg   = r_main.neg;
        out_par   = r_main.par;
        out_const = r_main.cnst;
        xfer_cnt  = r_xfer;
    end

endmodule
`default_nettype wire

// File: tb/tb_log_result_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_log_result_stage
//  Purpose  : Self-checking bench for log_result_stage. A queue-based model
//             (at most two held results, FIFO order, tag and transfer
//             counters) predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_log_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] lout = '0;
    logic [3:0]  sel = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [3:0]  out_sel;
    logic [7:0]  out_tag;
    logic        out_zero;
    logic        out_neg;
    logic        out_par;
    logic        out_const;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  s;
        logic [7:0]  t;
    } item_t;

    item_t       mq[$];
    logic [7:0]  m_tag  = '0;
    logic [15:0] m_xfer = '0;

    log_result_stage #(.DW(16), .TAGW(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .lout(lout), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sel(out_sel), .out_tag(out_tag),
        .out_zero(out_zero), .out_neg(out_neg), .out_par(out_par),
        .out_const(out_const), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Drive one cycle of inputs at negedge, advance the model at posedge,
    // leave time 1 unit after the edge for sampling.
    task automatic cycle(input logic v, input logic [15:0] d, input logic [3:0] s,
                         input logic ordy, input logic fl, input logic rs);
        logic  acc, drn;
        item_t it;
        @(negedge clk);
        in_valid = v; lout = d; sel = s; out_ready = ordy; flush = fl; rst = rs;
        acc = v && (mq.size() < 2) && !rs;
        drn = (mq.size() > 0) && ordy && !rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_tag  = '0;
            m_xfer = '0;
        end else begin
            if (drn) begin
                void'(mq.pop_front());
                m_xfer = m_xfer + 16'd1;
            end
            if (acc) begin
                it.d = d; it.s = s; it.t = m_tag;
                if (!fl) mq.push_back(it);
                m_tag = m_tag + 8'd1;
            end
            if (fl) mq.delete();
        end
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_during: got %b want 0", in_ready);
        end
        cycle(0, 16'h0, 4'h0, 0, 0, 1);
        cycle(0, 16'h0, 4'h0, 0, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || out_tag !== 8'h0 ||
            out_sel !== 4'h0 || out_zero !== 1'b0 || out_const !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b data=%h tag=%h sel=%h zero=%b const=%b want all 0",
                     out_valid, out_data, out_tag, out_sel, out_zero, out_const);
        end
        checks++;
        if (xfer_cnt !== 16'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cnt_ready: xfer=%0d ready=%b want 0/1", xfer_cnt, in_ready);
        end
    endtask

    task automatic test_first_result();
        cycle(1, 16'h0000, 4'b0011, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_const !== 1'b1 ||
            out_par !== 1'b0 || out_tag !== 8'd0) begin
            errors++;
            $display("FAIL first_result: valid=%b zero=%b const=%b par=%b tag=%0d want 1/1/1/0/0",
                     out_valid, out_zero, out_const, out_par, out_tag);
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd1) begin
            errors++; $display("FAIL first_drain: valid=%b xfer=%0d want 0/1", out_valid, xfer_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        logic        negs [4];
        logic        pars [4];
        logic [7:0]  t0;
        logic [15:0] x0;
        vals = '{16'h8001, 16'h00FF, 16'h7FFF, 16'hFFFF};
        negs = '{1'b1, 1'b0, 1'b0, 1'b1};
        pars = '{1'b0, 1'b0, 1'b1, 1'b0};
        t0 = m_tag;
        x0 = xfer_cnt;
        for (int i = 0; i < 4; i++) begin
            cycle(1, vals[i], 4'h6, 1, 0, 0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== vals[i] || out_tag !== t0 + 8'(i) ||
                out_neg !== negs[i] || out_par !== pars[i] || out_sel !== 4'h6) begin
                errors++;
                $display("FAIL stream[%0d]: valid=%b data=%h tag=%0d neg=%b par=%b want 1/%h/%0d/%b/%b",
                         i, out_valid, out_data, out_tag, out_neg, out_par,
                         vals[i], t0 + 8'(i), negs[i], pars[i]);
            end
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
        checks++;
        if (xfer_cnt !== x0 + 16'd4 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_xfer: xfer=%0d valid=%b want %0d/0", xfer_cnt, out_valid, x0 + 16'd4);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] t0;
        t0 = m_tag;
        cycle(1, 16'hA001, 4'h1, 0, 0, 0);
        cycle(1, 16'hA002, 4'h2, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 16'hA001 || out_tag !== t0) begin
            errors++; $display("FAIL bp_full: ready=%b data=%h tag=%0d want 0/a001/%0d", in_ready, out_data, out_tag, t0);
        end
        cycle(1, 16'hA003, 4'h3, 0, 0, 0);
        checks++;
        if (in_ready !== 1'b0 || out_data !== 16'hA001 || out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: ready=%b data=%h valid=%b want 0/a001/1", in_ready, out_data, out_valid);
        end
        cycle(1, 16'hA003, 4'h3, 1, 0, 0);
        checks++;
        if (in_ready !== 1'b1 || out_data !== 16'hA002 || out_tag !== t0 + 8'd1) begin
            errors++; $display("FAIL bp_first_drain: ready=%b data=%h tag=%0d want 1/a002/%0d", in_ready, out_data, out_tag, t0 + 8'd1);
        end
        cycle(1, 16'hA003, 4'h3, 1, 0, 0);
        checks++;
        if (out_data !== 16'hA003 || out_tag !== t0 + 8'd2 || out_const !== 1'b1) begin
            errors++; $display("FAIL bp_third: data=%h tag=%0d const=%b want a003/%0d/1", out_data, out_tag, out_const, t0 + 8'd2);
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== m_xfer) begin
            errors++; $display("FAIL bp_end: valid=%b xfer=%0d want 0/%0d", out_valid, xfer_cnt, m_xfer);
        end
    endtask

    task automatic test_flush();
        logic [7:0]  t0;
        logic [15:0] x0;
        t0 = m_tag;
        cycle(1, 16'h1111, 4'h4, 0, 0, 0);
        cycle(1, 16'h2222, 4'h4, 0, 0, 0);
        cycle(1, 16'h3333, 4'h4, 0, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_full: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        cycle(1, 16'h3333, 4'h4, 0, 0, 0);
        checks++;
        if (out_tag !== t0 + 8'd2 || out_data !== 16'h3333) begin
            errors++; $display("FAIL flush_next_tag: tag=%0d data=%h want %0d/3333", out_tag, out_data, t0 + 8'd2);
        end
        // Flush in ONE with a drain and an accept: drain counts, accept is
        // dropped but still consumes a tag.
        x0 = xfer_cnt;
        cycle(1, 16'h4444, 4'h4, 1, 1, 0);
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== x0 + 16'd1) begin
            errors++; $display("FAIL flush_drain: valid=%b xfer=%0d want 0/%0d", out_valid, xfer_cnt, x0 + 16'd1);
        end
        cycle(1, 16'h5555, 4'h4, 1, 0, 0);
        checks++;
        if (out_tag !== t0 + 8'd4 || out_data !== 16'h5555) begin
            errors++; $display("FAIL flush_tag_skip: tag=%0d data=%h want %0d/5555", out_tag, out_data, t0 + 8'd4);
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
    endtask

    task automatic test_tag_wrap();
        int          wrap_seen;
        logic [7:0]  prev;
        wrap_seen = 0;
        cycle(0, 16'h0, 4'h0, 0, 0, 1);
        for (int i = 0; i < 256; i++) begin
            cycle(1, 16'(i * 7), 4'h5, 1, 0, 0);
            if (i > 0 && prev == 8'd255 && out_tag == 8'd0) wrap_seen++;
            prev = out_tag;
            if (i == 255) begin
                checks++;
                if (out_tag !== 8'd255) begin
                    errors++; $display("FAIL tag_last: got %0d want 255", out_tag);
                end
            end
        end
        cycle(1, 16'h0, 4'h5, 1, 0, 0);
        checks++;
        if (out_tag !== 8'd0 || prev !== 8'd255) begin
            errors++; $display("FAIL tag_wrap: got %0d after %0d want 0 after 255", out_tag, prev);
        end
        checks++;
        if (xfer_cnt !== 16'd256) begin
            errors++; $display("FAIL xfer_256: got %0d want 256", xfer_cnt);
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
    endtask

    task automatic test_xfer_wrap();
        cycle(0, 16'h0, 4'h0, 0, 0, 1);
        for (int i = 0; i < 65536; i++) begin
            cycle(1, 16'(i), 4'h9, 1, 0, 0);
        end
        checks++;
        if (xfer_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL xfer_pre_wrap: got %0d want 65535", xfer_cnt);
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
        checks++;
        if (xfer_cnt !== 16'h0000) begin
            errors++; $display("FAIL xfer_wrap: got %0d want 0", xfer_cnt);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 16'hBEEF, 4'h1, 0, 0, 0);
        cycle(1, 16'hCAFE, 4'h2, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_ready_during: got %b want 0", in_ready);
        end
        cycle(1, 16'h0, 4'h0, 1, 0, 1);
        checks++;
        if (out_valid !== 1'b0 || xfer_cnt !== 16'd0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: valid=%b xfer=%0d ready=%b want 0/0/0", out_valid, xfer_cnt, in_ready);
        end
        cycle(0, 16'h0, 4'h0, 1, 0, 0);
        checks++;
        if (in_ready !== 1'b1 || xfer_cnt !== 16'd0) begin
            errors++; $display("FAIL rstmid_after: ready=%b xfer=%0d want 1/0", in_ready, xfer_cnt);
        end
    endtask

    task automatic test_random();
        logic [3:0]  s;
        logic        exp_zero, exp_const;
        for (int i = 0; i < 2000; i++) begin
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) s = ($urandom_range(0, 1) == 0) ? 4'b0011 : 4'b1100;
            cycle(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                  s,
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 199) == 0));
            checks++;
            if (out_valid !== (mq.size() != 0) || in_ready !== ((mq.size() < 2) && !rst) ||
                xfer_cnt !== m_xfer) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: valid=%b ready=%b xfer=%0d want %b/%b/%0d", i,
                         out_valid, in_ready, xfer_cnt, mq.size() != 0,
                         (mq.size() < 2) && !rst, m_xfer);
            end
            if (mq.size() != 0) begin
                exp_zero  = (mq[0].d == 16'h0);
                exp_const = (mq[0].s == 4'b0011) || (mq[0].s == 4'b1100);
                checks++;
                if (out_data !== mq[0].d || out_sel !== mq[0].s || out_tag !== mq[0].t ||
                    out_zero !== exp_zero || out_neg !== mq[0].d[15] ||
                    out_par !== (^mq[0].d) || out_const !== exp_const) begin
                    errors++;
                    $display("FAIL rand_data[%0d]: data=%h sel=%h tag=%0d z=%b n=%b p=%b c=%b want %h/%h/%0d/%b/%b/%b/%b",
                             i, out_data, out_sel, out_tag, out_zero, out_neg, out_par, out_const,
                             mq[0].d, mq[0].s, mq[0].t, exp_zero, mq[0].d[15], ^mq[0].d, exp_const);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_result();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_tag_wrap();
        test_xfer_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
